alu_deserializer: RTL

ALU_DESERIALIZER -- requirements
Module: alu_deserializer

---
 rtl/alu_deserializer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_deserializer.sv
// Serial command deserializer for the ALU core: collects 8 DATA frames plus one CTL frame,
// checks framing, CRC4 and opcode, then presents operands with a valid/ready handshake.
module alu_deserializer #(
    parameter int unsigned STOP_CHECK = 1
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        sin,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [2:0]  op_o,
    output logic        err_valid_o,
    output logic [2:0]  err_o,
    output logic        ovr_o
);

    typedef enum logic [1:0] {StIdle, StType, StBits, StStop} state_e;

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        type_q, type_d;
    logic [7:0]  byte_q, byte_d;
    logic [63:0] data_q, data_d;
    logic [3:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]  crc_q, crc_d;
    logic        discard_q, discard_d;
    logic        valid_q, valid_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        err_valid_q, err_valid_d;
    logic [2:0]  err_q, err_d;
    logic        ovr_q, ovr_d;

    logic [3:0]  crc_final;
    logic        stop_bad;

    // One serial step of CRC4, polynomial x^4+x+1.
    function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
        logic fb;
        fb = c[3] ^ b;
        return {c[2], c[1], c[0] ^ fb, fb};
    endfunction

    // The CTL frame's leading bit is 0 on the line but enters the CRC as 1.
    assign crc_final = crc4_step(crc4_step(crc4_step(crc4_step(crc_q, 1'b1),
                                 byte_q[6]), byte_q[5]), byte_q[4]);
    assign stop_bad  = (STOP_CHECK != 0) && !sin;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        type_d      = type_q;
        byte_d      = byte_q;
        data_d      = data_q;
        frame_cnt_d = frame_cnt_q;
        crc_d       = crc_q;
        discard_d   = discard_q;
        valid_d     = valid_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        err_valid_d = 1'b0;
        err_d       = 3'b000;
        ovr_d       = ovr_q;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (!sin) begin
                    if (valid_q && !ready_i) begin
                        ovr_d = 1'b1;
                    end else begin
                        state_d = StType;
                    end
                end
            end
            StType: begin
                type_d    = sin;
                bit_cnt_d = 3'd7;
                state_d   = StBits;
            end
            StBits: begin
                byte_d = {byte_q[6:0], sin};
                if (!type_q && !discard_q) begin
                    data_d = {data_q[62:0], sin};
                    crc_d  = crc4_step(crc_q, sin);
                end
                if (bit_cnt_q == 3'd0) begin
                    state_d = StStop;
                end else begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                end
            end
            StStop: begin
                state_d = StIdle;
                if (discard_q) begin
                    if (type_q) begin
                        discard_d = 1'b0;
                    end
                end else if (!type_q && !stop_bad && frame_cnt_q != 4'd8) begin
                    frame_cnt_d = frame_cnt_q + 4'd1;
                end else begin
                    // Every report or accept restarts collection from frame 0.
                    frame_cnt_d = 4'd0;
                    crc_d       = 4'd0;
                    if (!type_q || stop_bad || frame_cnt_q != 4'd8) begin
                        err_valid_d = 1'b1;
                        err_d       = 3'b100;
                        discard_d   = 1'b1;
                    end else if (byte_q[3:0] != crc_final) begin
                        err_valid_d = 1'b1;
                        err_d       = 3'b010;
                    end else if (byte_q[5]) begin
                        err_valid_d = 1'b1;
                        err_d       = 3'b001;
                    end else begin
                        valid_d = 1'b1;
                        b_d     = data_q[63:32];
                        a_d     = data_q[31:0];
                        op_d    = byte_q[6:4];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            type_q      <= 1'b0;
            byte_q      <= 8'd0;
            data_q      <= 64'd0;
            frame_cnt_q <= 4'd0;
            crc_q       <= 4'd0;
            discard_q   <= 1'b0;
            valid_q     <= 1'b0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            op_q        <= 3'd0;
            err_valid_q <= 1'b0;
            err_q       <= 3'd0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            type_q      <= type_d;
            byte_q      <= byte_d;
            data_q      <= data_d;
            frame_cnt_q <= frame_cnt_d;
            crc_q       <= crc_d;
            discard_q   <= discard_d;
            valid_q     <= valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            err_valid_q <= err_valid_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
        end
    end

    assign valid_o     = valid_q;
    assign a_o         = a_q;
    assign b_o         = b_q;
    assign op_o        = op_q;
    assign err_valid_o = err_valid_q;
    assign err_o       = err_q;
    assign ovr_o       = ovr_q;

endmodule
